mc_main_fsm: RTL and testbench
==============================

MC_MAIN_FSM -- requirements
Module: mc_main_fsm

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have the port op, input, 7 bits: opcode field of the instruction register.
REQ-004 The block SHALL have the port zero, input, 1 bit: ALU zero flag.
REQ-005 The block SHALL have the port mem_ready, input, 1 bit: memory access completes this cycle.
REQ-006 The block SHALL have these outputs:
- PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite: 1 bit each.
- ResultSrc, ALUSrcA, ALUSrcB, ALUOp: 2 bits each.
- illegal: 1 bit, unknown-opcode pulse.

Function
REQ-007 The FSM SHALL have these states: IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
REQ-008 Transitions SHALL be:
- IDLE->FETCH unconditionally.
- FETCH->DECODE.
- DECODE by op:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECUTER.
  - 0010011 -> EXECUTEI.
  - 1100011 -> BEQ.
  - 1101111 -> JAL.
  - any other -> FETCH.
- MEMADR->MEMREAD for op 0000011, ->MEMWRITE for op 0100011.
- MEMREAD->MEMWB.
- EXECUTER and EXECUTEI -> ALUWB.
- JAL -> ALUWB.
- MEMWB, MEMWRITE, ALUWB and BEQ -> FETCH.
REQ-009 Outputs SHALL be decoded from the current state only (Moore), except PCWrite, which SHALL equal PCUpdate OR (Branch AND zero).
REQ-010 Every output not listed for a state in REQ-011 SHALL be 0 in that state. IDLE drives all outputs 0.
REQ-011 Per-state outputs (A = ALUSrcA, B = ALUSrcB, R = ResultSrc) SHALL be:
- FETCH: AdrSrc=0, IRWrite=1, A=00, B=10, ALUOp=00, R=10, PCUpdate=1.
- DECODE: A=01, B=01, ALUOp=00.
- MEMADR: A=10, B=01, ALUOp=00.
- MEMREAD: R=00, AdrSrc=1.
- MEMWB: R=01, RegWrite=1.
- MEMWRITE: R=00, AdrSrc=1, MemWrite=1.
- EXECUTER: A=10, B=00, ALUOp=10.
- EXECUTEI: A=10, B=01, ALUOp=10.
- ALUWB: R=00, RegWrite=1.
- BEQ: A=10, B=00, ALUOp=01, R=00, Branch=1.
- JAL: A=01, B=10, ALUOp=00, R=00, PCUpdate=1.
REQ-012 illegal SHALL pulse high for exactly the one DECODE cycle in which op is unrecognised, and the FSM SHALL then return to FETCH.
REQ-013 Instruction latency without stalls SHALL be: lw 5 cycles, sw 4, R-type 4, I-type 4, jal 4, beq 3.
REQ-014 op SHALL be sampled only in DECODE and MEMADR; changes to op in any other state SHALL have no effect.

Reset
REQ-015 Asserting rst_n low SHALL force state IDLE immediately, independent of clk, including in the middle of an instruction.
REQ-016 While reset is asserted, all outputs SHALL be 0.
REQ-017 After rst_n deasserts, the first rising clk edge SHALL move the FSM from IDLE to FETCH.

Configuration
REQ-018 When macro MC_MEM_WAIT_EN is defined, wait-state handling SHALL be enabled:
- FETCH, MEMREAD and MEMWRITE hold their state until mem_ready=1.
- In FETCH, IRWrite and PCWrite assert only in the cycle where mem_ready=1.
- In MEMWRITE, MemWrite stays high for every cycle until mem_ready=1.
REQ-019 When MC_MEM_WAIT_EN is undefined, mem_ready SHALL be ignored and each of those states SHALL last exactly one cycle.

Structure
REQ-020 A shared package riscv_ctrl_pkg SHALL hold:
- the state enum;
- opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL);
- the ALUOp, ResultSrc, ALUSrcA and ALUSrcB encodings.
REQ-021 The state-to-control table SHALL be one combinational sub-module, mc_ctrl_outdec. State register and next-state logic SHALL stay in mc_main_fsm.

Verification
REQ-022 Reset: rst_n=0 asynchronously in MEMREAD -> state=IDLE and all outputs 0 before the next clk edge; the FSM reaches FETCH 1 cycle after release.
REQ-023 lw: op=0000011 -> state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 with ResultSrc=01 in cycle 5.
REQ-024 beq: op=1100011 with zero=1 -> PCWrite=1 and ALUOp=01 in cycle 3. The same with zero=0 -> PCWrite=0.
REQ-025 Illegal op: op=1111111 -> illegal=1 for one cycle in DECODE, then FETCH with no RegWrite or MemWrite pulse.
REQ-026 Wait states (MC_MEM_WAIT_EN defined): sw with mem_ready low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, then FETCH.
REQ-027 No wait states (MC_MEM_WAIT_EN undefined): mem_ready held 0 -> R-type op=0110011 completes in 4 cycles.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V main control FSM:
// state enum, opcode constants, datapath mux/ALU encodings and the
// control bundle passed from the output decoder to the top.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BEQ,
        JAL
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // ALUOp
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ResultSrc
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALUSrcA
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALUSrcB
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic is_known_op(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// State-to-control table for the main FSM (Moore decode).
// mem_go gates the FETCH write strobes; it is tied high by the top
// unless MC_MEM_WAIT_EN is defined.
module mc_ctrl_outdec
    import riscv_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_go,
    output ctrl_t  ctrl
);

    // Decode one control bundle per state; everything unlisted stays 0
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.adr_src    = 1'b0;
                ctrl.ir_write   = mem_go;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURESULT;
                ctrl.pc_update  = mem_go;
            end
            DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMREAD: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.adr_src    = 1'b1;
            end
            MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.adr_src    = 1'b1;
                ctrl.mem_write  = 1'b1;
            end
            EXECUTER: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            BEQ: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
            end
            JAL: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_update  = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_fsm.sv
// Multi-cycle RISC-V main control FSM: state register, next-state logic
// and the illegal-opcode pulse. Control outputs come from mc_ctrl_outdec.
// Define MC_MEM_WAIT_EN to make FETCH/MEMREAD/MEMWRITE wait for mem_ready.
module mc_main_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       illegal
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;
    logic   mem_go;

`ifdef MC_MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    logic unused_mem_ready;
    assign mem_go           = 1'b1;
    assign unused_mem_ready = mem_ready;
`endif

    // State register; reset drops straight to IDLE mid-instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state selection; op is only looked at in DECODE and MEMADR
    always_comb begin
        state_next = state;
        illegal    = 1'b0;
        case (state)
            IDLE:   state_next = FETCH;
            FETCH:  state_next = mem_go ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECUTER;
                    OP_I:         state_next = EXECUTEI;
                    OP_BEQ:       state_next = BEQ;
                    OP_JAL:       state_next = JAL;
                    default:      state_next = FETCH;
                endcase
                illegal = !is_known_op(op);
            end
            MEMADR: begin
                if (op == OP_LW)      state_next = MEMREAD;
                else if (op == OP_SW) state_next = MEMWRITE;
                else                  state_next = FETCH;
            end
            MEMREAD:  state_next = mem_go ? MEMWB : MEMREAD;
            MEMWRITE: state_next = mem_go ? FETCH : MEMWRITE;
            EXECUTER: state_next = ALUWB;
            EXECUTEI: state_next = ALUWB;
            JAL:      state_next = ALUWB;
            MEMWB:    state_next = FETCH;
            ALUWB:    state_next = FETCH;
            BEQ:      state_next = FETCH;
            default:  state_next = IDLE;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .state  (state),
        .mem_go (mem_go),
        .ctrl   (ctrl)
    );

    assign PCWrite   = ctrl.pc_update | (ctrl.branch & zero);
    assign AdrSrc    = ctrl.adr_src;
    assign MemWrite  = ctrl.mem_write;
    assign IRWrite   = ctrl.ir_write;
    assign RegWrite  = ctrl.reg_write;
    assign ResultSrc = ctrl.result_src;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ALUOp     = ctrl.alu_op;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Scoreboard bench for mc_main_fsm. Expected per-cycle output vectors are
// derived from instruction-level phase sequences and pushed by the driver;
// a negedge monitor pops and compares. Honours MC_MEM_WAIT_EN.
module tb_mc_main_fsm;

    localparam logic [6:0] LW_OP  = 7'b0000011;
    localparam logic [6:0] SW_OP  = 7'b0100011;
    localparam logic [6:0] R_OP   = 7'b0110011;
    localparam logic [6:0] I_OP   = 7'b0010011;
    localparam logic [6:0] BEQ_OP = 7'b1100011;
    localparam logic [6:0] JAL_OP = 7'b1101111;

`ifdef MC_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] op = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;

    mc_main_fsm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .zero      (zero),
        .mem_ready (mem_ready),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal}
    logic [13:0] got;
    assign got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal};

    typedef struct {
        string       name;
        logic [13:0] vec;
    } exp_t;

    exp_t        sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    bit          mon_en = 1'b0;
    int          zero_mode = 2;   // 0/1 force, 2 random
    int          mr_mode = 0;     // 0 random, 1 force 0, 2 force 1
    int          mw_stalls = 0;   // forced mem_ready=0 cycles in MEMWRITE

    task automatic check(input string name, input logic [13:0] g, input logic [13:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s got=%b exp=%b t=%0t", name, g, e, $time);
        end
    endtask

    function automatic bit legal(input logic [6:0] o);
        logic [6:0] tbl [6];
        tbl = '{LW_OP, SW_OP, R_OP, I_OP, BEQ_OP, JAL_OP};
        foreach (tbl[i]) if (tbl[i] == o) return 1'b1;
        return 1'b0;
    endfunction

    // Output table by phase name
    function automatic logic [13:0] exp_vec(input string ph, input bit z,
                                            input bit stall, input bit ill);
        bit pcw, adr, mw, irw, rw, il;
        logic [1:0] r, a, b, aop;
        {pcw, adr, mw, irw, rw, il} = '0;
        {r, a, b, aop} = '0;
        if (ph == "FETCH") begin
            irw = !stall; pcw = !stall; b = 2'b10; r = 2'b10;
        end else if (ph == "DECODE") begin
            a = 2'b01; b = 2'b01; il = ill;
        end else if (ph == "MEMADR") begin
            a = 2'b10; b = 2'b01;
        end else if (ph == "MEMREAD") begin
            adr = 1'b1;
        end else if (ph == "MEMWB") begin
            r = 2'b01; rw = 1'b1;
        end else if (ph == "MEMWRITE") begin
            adr = 1'b1; mw = 1'b1;
        end else if (ph == "EXECUTER") begin
            a = 2'b10; aop = 2'b10;
        end else if (ph == "EXECUTEI") begin
            a = 2'b10; b = 2'b01; aop = 2'b10;
        end else if (ph == "ALUWB") begin
            rw = 1'b1;
        end else if (ph == "BEQ") begin
            a = 2'b10; aop = 2'b01; pcw = z;
        end else if (ph == "JAL") begin
            a = 2'b01; b = 2'b10; pcw = 1'b1;
        end
        return {pcw, adr, mw, irw, rw, r, a, b, aop, il};
    endfunction

    // One clock of stimulus plus its expected output vector
    task automatic step(input string ph, input logic [6:0] op_drive,
                        input bit waitable, input bit ill, output bit stalled);
        logic mr, z;
        exp_t e;
        @(posedge clk);
        #1;
        z = (zero_mode == 2) ? 1'($urandom_range(0, 1)) : (zero_mode == 1);
        if (ph == "MEMWRITE" && mw_stalls > 0) begin
            mr = 1'b0;
            mw_stalls--;
        end else if (mr_mode == 1) mr = 1'b0;
        else if (mr_mode == 2)     mr = 1'b1;
        else                       mr = ($urandom_range(0, 2) != 0);
        op        = op_drive;
        zero      = z;
        mem_ready = mr;
        stalled   = WAIT_EN && waitable && !mr;
        e.name    = ph;
        e.vec     = exp_vec(ph, z, stalled, ill);
        sb.push_back(e);
    endtask

    task automatic wait_phase(input string ph);
        bit st;
        int unsigned n = 0;
        do begin
            step(ph, 7'($urandom), 1'b1, 1'b0, st);
            n++;
        end while (st && n < 50);
    endtask

    task automatic run_instr(input logic [6:0] opi);
        bit st;
        wait_phase("FETCH");
        step("DECODE", opi, 1'b0, !legal(opi), st);
        if (opi == LW_OP || opi == SW_OP) begin
            step("MEMADR", opi, 1'b0, 1'b0, st);
            if (opi == LW_OP) begin
                wait_phase("MEMREAD");
                step("MEMWB", 7'($urandom), 1'b0, 1'b0, st);
            end else begin
                wait_phase("MEMWRITE");
            end
        end else if (opi == R_OP) begin
            step("EXECUTER", 7'($urandom), 1'b0, 1'b0, st);
            step("ALUWB", 7'($urandom), 1'b0, 1'b0, st);
        end else if (opi == I_OP) begin
            step("EXECUTEI", 7'($urandom), 1'b0, 1'b0, st);
            step("ALUWB", 7'($urandom), 1'b0, 1'b0, st);
        end else if (opi == BEQ_OP) begin
            step("BEQ", 7'($urandom), 1'b0, 1'b0, st);
        end else if (opi == JAL_OP) begin
            step("JAL", 7'($urandom), 1'b0, 1'b0, st);
            step("ALUWB", 7'($urandom), 1'b0, 1'b0, st);
        end
    endtask

    task automatic release_reset();
        exp_t e;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        e.name = "IDLE";
        e.vec  = '0;
        sb.push_back(e);
        mon_en = 1'b1;
    endtask

    // Monitor: compare DUT outputs with the oldest expectation
    always @(negedge clk) begin
        if (mon_en && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.name, got, e.vec);
        end
    end

    initial begin
        logic [6:0] rop;
        bit st;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            op = 7'($urandom); zero = 1'b1; mem_ready = 1'($urandom_range(0, 1));
            #1 check("reset_outputs", got, '0);
            @(negedge clk);
        end
        release_reset();

        run_instr(LW_OP);
        run_instr(SW_OP);
        mr_mode = WAIT_EN ? 0 : 1;
        run_instr(R_OP);
        mr_mode = 0;
        run_instr(I_OP);
        run_instr(JAL_OP);
        zero_mode = 1; run_instr(BEQ_OP);
        zero_mode = 0; run_instr(BEQ_OP);
        zero_mode = 2;
        run_instr(7'h7f);
        mw_stalls = 3; run_instr(SW_OP); mw_stalls = 0;

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 7))
                0: rop = LW_OP;
                1: rop = SW_OP;
                2: rop = R_OP;
                3: rop = I_OP;
                4: rop = BEQ_OP;
                5: rop = JAL_OP;
                6: rop = 7'($urandom);
                default: rop = 7'h7f;
            endcase
            run_instr(rop);
        end

        // Asynchronous reset while in MEMREAD
        mr_mode = 2;
        wait_phase("FETCH");
        step("DECODE", LW_OP, 1'b0, 1'b0, st);
        step("MEMADR", LW_OP, 1'b0, 1'b0, st);
        step("MEMREAD", 7'($urandom), 1'b1, 1'b0, st);
        mr_mode = 0;
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        zero   = 1'b1;
        rst_n  = 1'b0;
        #1 check("async_reset_idle", got, '0);
        @(posedge clk);
        #1 check("reset_across_edge", got, '0);
        release_reset();
        run_instr(R_OP);
        run_instr(LW_OP);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL queue_drain left=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
